// File: rtl/scanlines.sv
// scanlines: scanline-effect stage between the scandoubler and the video DAC.
//
// Darkens every other output line of the doubled (31kHz) stream by a selectable
// amount. With enable low (15kHz bypass), video passes through bit-exact. Sync
// and RGB share one two-stage pipeline, so their timing relationship is kept.
//
// Ports
//   clock   in   1     system clock
//   reset   in   1     synchronous, active-high reset
//   ce      in   1     output pixel clock enable; every register holds while low
//   enable  in   1     1 = doubled video (apply effect), 0 = pass-through
//   mode    in   2     0 off, 1 light (75%), 2 medium (50%), 3 dark (25%)
//   phase   in   1     0 = darken odd lines, 1 = darken even lines
//   isync   in   2     {vsync, hsync}, active-high
//   irgb    in   RGBW  pixel from the scandoubler, already blanked
//   osync   out  2     isync delayed by two ce ticks
//   orgb    out  RGBW  processed pixel, delayed by two ce ticks
//
// Handshake: none. This is a free-running stream qualified only by ce; a pixel
// enters stage 1 on a ce tick and leaves stage 2 on the next ce tick.
//
// RGBW must be a multiple of 3 (three equal channels, R in the MSBs).

module scanlines #(
  parameter int RGBW = 18
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ce,
  input  logic            enable,
  input  logic [1:0]      mode,
  input  logic            phase,
  input  logic [1:0]      isync,
  input  logic [RGBW-1:0] irgb,
  output logic [1:0]      osync,
  output logic [RGBW-1:0] orgb
);

  localparam int CW = RGBW / 3;

  // sync edge detection and line/frame state
  logic       hs_d;
  logic       vs_d;
  logic       parity;
  logic [1:0] mode_l;
  logic       phase_l;
  logic       hs_rise;
  logic       vs_fall;

  // stage 1
  logic [RGBW-1:0] rgb1;
  logic [1:0]      sync1;
  logic            dark1;
  logic [1:0]      mode1;

  logic [RGBW-1:0] shaded;

  assign hs_rise = !hs_d && isync[0];
  assign vs_fall = vs_d && !isync[1];

  function automatic logic [CW-1:0] shade(input logic [CW-1:0] c, input logic [1:0] m);
    logic [CW-1:0] r;
    case (m)
      2'd1:    r = c - (c >> 2);
      2'd2:    r = c >> 1;
      2'd3:    r = c >> 2;
      default: r = c;
    endcase
    return r;
  endfunction

  // Stage 1 carries the mode that was latched when its pixel entered, so a
  // mode reload on the next tick cannot affect a pixel already in flight.
  always_comb begin
    shaded = rgb1;
    for (int i = 0; i < 3; i++) begin
      shaded[i*CW +: CW] = shade(rgb1[i*CW +: CW], mode1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hs_d    <= 1'b0;
      vs_d    <= 1'b0;
      parity  <= 1'b0;
      mode_l  <= 2'd0;
      phase_l <= 1'b0;
      rgb1    <= '0;
      sync1   <= 2'b00;
      dark1   <= 1'b0;
      mode1   <= 2'd0;
      osync   <= 2'b00;
      orgb    <= '0;
    end else if (ce) begin
      hs_d <= isync[0];
      vs_d <= isync[1];

      // Bypass keeps parity cleared and tracks mode/phase continuously, so the
      // selected effect is already in place when doubled video returns.
      // Otherwise mode/phase only change at the vsync falling edge, and that
      // edge also wins over a coincident hsync rise: first line is even.
      if (!enable) begin
        parity  <= 1'b0;
        mode_l  <= mode;
        phase_l <= phase;
      end else if (vs_fall) begin
        parity  <= 1'b0;
        mode_l  <= mode;
        phase_l <= phase;
      end else if (hs_rise) begin
        parity  <= ~parity;
      end

      // enable is sampled live so a mid-line toggle affects the very pixel
      // entering on this tick.
      rgb1  <= irgb;
      sync1 <= isync;
      dark1 <= enable && (mode_l != 2'd0) && (parity != phase_l);
      mode1 <= mode_l;

      osync <= sync1;
      orgb  <= dark1 ? shaded : rgb1;
    end
  end

endmodule

// File: tb/tb_scanlines.sv
module tb_scanlines;

  localparam int RGBW = 18;
  localparam int CW   = 6;

  // ---------------- clock / reset / DUT ----------------
  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            ce = 1'b0;
  logic            enable = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic            phase = 1'b0;
  logic [1:0]      isync = 2'b00;
  logic [RGBW-1:0] irgb = '0;
  logic [1:0]      osync;
  logic [RGBW-1:0] orgb;

  always #5 clock = ~clock;

  scanlines #(.RGBW(RGBW)) dut (
    .clock(clock), .reset(reset), .ce(ce), .enable(enable), .mode(mode),
    .phase(phase), .isync(isync), .irgb(irgb), .osync(osync), .orgb(orgb)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Output is whatever was computed for the pixel that entered one ce tick
  // before the most recent one; the queue holds that one-pixel backlog.
  logic [RGBW+1:0] exp_q[$];
  logic [RGBW+1:0] cur_exp;
  bit              m_par, m_pl, m_hs, m_vs;
  int              m_ml;

  function automatic logic [RGBW-1:0] m_shade(input logic [RGBW-1:0] p, input int m);
    logic [RGBW-1:0] r;
    r = p;
    for (int ch = 0; ch < 3; ch++) begin
      int c;
      c = int'(p[ch*CW +: CW]);
      if (m == 1) c = c - c / 4;
      else if (m == 2) c = c / 2;
      else if (m == 3) c = c / 4;
      r[ch*CW +: CW] = c[CW-1:0];
    end
    return r;
  endfunction

  task automatic model_reset();
    exp_q = {};
    exp_q.push_back('0);
    cur_exp = '0;
    m_par = 0; m_pl = 0; m_hs = 0; m_vs = 0; m_ml = 0;
  endtask

  task automatic model_tick();
    bit dark, hr, vf;
    logic [RGBW-1:0] v;
    dark = enable && (m_ml != 0) && (m_par != m_pl);
    v = dark ? m_shade(irgb, m_ml) : irgb;
    exp_q.push_back({isync, v});
    cur_exp = exp_q.pop_front();
    hr = !m_hs && isync[0];
    vf = m_vs && !isync[1];
    if (!enable || vf) begin
      m_par = 0; m_ml = int'(mode); m_pl = phase;
    end else if (hr) begin
      m_par = !m_par;
    end
    m_hs = isync[0];
    m_vs = isync[1];
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit c, input logic [1:0] s, input logic [RGBW-1:0] p);
    ce = c; isync = s; irgb = p;
    @(posedge clock);
    if (c) model_tick();
    #1;
    chk("model_osync", 32'(osync), 32'(cur_exp[RGBW+1:RGBW]));
    chk("model_orgb", 32'(orgb), 32'(cur_exp[RGBW-1:0]));
  endtask

  task automatic do_reset();
    reset = 1'b1; ce = 1'b1; irgb = '1; isync = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      model_reset();
      #1;
      chk("reset_osync", 32'(osync), 32'h0);
      chk("reset_orgb", 32'(orgb), 32'h0);
    end
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  // One frame: vsync pulse, one pixel on line 0, then three hsync-delimited
  // lines with one pixel each. exp_kind: 0 zero, 1 bright pixel, 2 dark pixel.
  typedef struct {
    logic [1:0] sync;
    bit         pix;
    logic [1:0] exp_sync;
    int         exp_kind;
  } vec_t;
  vec_t tbl[10];

  task automatic run_table(input logic [1:0] m, input logic [RGBW-1:0] bright,
                           input logic [RGBW-1:0] dark_v);
    logic [RGBW-1:0] e;
    enable = 1'b1; mode = m; phase = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, tbl[i].sync, tbl[i].pix ? bright : '0);
      e = (tbl[i].exp_kind == 1) ? bright : (tbl[i].exp_kind == 2) ? dark_v : '0;
      chk($sformatf("tbl_m%0d_sync_%0d", m, i), 32'(osync), 32'(tbl[i].exp_sync));
      chk($sformatf("tbl_m%0d_rgb_%0d", m, i), 32'(orgb), 32'(e));
    end
  endtask

  localparam logic [RGBW-1:0] ONES = 18'h3FFFF;
  localparam logic [RGBW-1:0] C40  = 18'h28A28;

  initial begin
    tbl[0] = '{2'b10, 1'b0, 2'b00, 0};
    tbl[1] = '{2'b00, 1'b1, 2'b10, 0};
    tbl[2] = '{2'b01, 1'b0, 2'b00, 1};
    tbl[3] = '{2'b00, 1'b1, 2'b01, 0};
    tbl[4] = '{2'b01, 1'b0, 2'b00, 2};
    tbl[5] = '{2'b00, 1'b1, 2'b01, 0};
    tbl[6] = '{2'b01, 1'b0, 2'b00, 1};
    tbl[7] = '{2'b00, 1'b1, 2'b01, 0};
    tbl[8] = '{2'b00, 1'b0, 2'b00, 2};
    tbl[9] = '{2'b00, 1'b0, 2'b00, 0};

    // reset, then pipeline latency with all-ones input in bypass
    enable = 1'b0; mode = 2'd0;
    do_reset();
    cyc(1'b1, 2'b11, ONES);
    chk("latency_tick1", 32'(orgb), 32'h0);
    cyc(1'b1, 2'b11, ONES);
    chk("latency_tick2_rgb", 32'(orgb), 32'(ONES));
    chk("latency_tick2_sync", 32'(osync), 32'h3);

    // alternating lines at each strength
    run_table(2'd2, ONES, 18'h1F7DF);
    run_table(2'd1, C40, 18'h1E79E);
    run_table(2'd3, C40, 18'h0A28A);

    // mode change mid-frame only takes effect after the next vsync fall
    enable = 1'b1; mode = 2'd2; phase = 1'b0;
    do_reset();
    cyc(1'b1, 2'b10, '0);
    cyc(1'b1, 2'b00, '0);
    cyc(1'b1, 2'b01, '0);
    mode = 2'd3;
    cyc(1'b1, 2'b00, ONES);
    cyc(1'b1, 2'b00, '0);
    chk("midframe_keeps_50", 32'(orgb), 32'h1F7DF);
    cyc(1'b1, 2'b10, '0);
    cyc(1'b1, 2'b00, '0);
    cyc(1'b1, 2'b01, '0);
    cyc(1'b1, 2'b00, ONES);
    cyc(1'b1, 2'b00, '0);
    chk("nextframe_25", 32'(orgb), 32'h0F3CF);

    // vsync fall and hsync rise on the same tick: next line stays bright
    mode = 2'd2;
    do_reset();
    cyc(1'b1, 2'b10, '0);
    cyc(1'b1, 2'b01, ONES);
    cyc(1'b1, 2'b00, ONES);
    chk("coincident_line0_a", 32'(orgb), 32'(ONES));
    cyc(1'b1, 2'b00, '0);
    chk("coincident_line0_b", 32'(orgb), 32'(ONES));

    // bypass with half-rate ce: plain 2-tick delay
    enable = 1'b0; mode = 2'd3;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc(1'(($urandom_range(0, 1))), 2'($urandom_range(0, 3)), 18'($urandom));
    end

    // doubled video, random modes/phase/enable and sparse sync pulses
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] s;
      if (($urandom_range(0, 15)) == 0) mode = 2'($urandom_range(0, 3));
      if (($urandom_range(0, 15)) == 0) phase = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 19) != 0);
      s[1] = ($urandom_range(0, 29) == 0);
      s[0] = ($urandom_range(0, 5) == 0);
      cyc(1'(($urandom_range(0, 3) != 0)), s, 18'($urandom));
    end

    // reset mid-frame, then resume
    do_reset();
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))}, 18'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
